// File: rtl/switch_scheduler_rr.sv
// Crossbar scheduler: per-output round-robin arbitration over input FIFO heads.
// Define SCHED_DROP_EN to pop and count undeliverable heads (drop_cnt port).
module switch_scheduler_rr #(
    parameter int NPORTS = 3,
    parameter int DATA_W = 8,
    parameter int DEST_W = 2,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NPORTS*DATA_W-1:0] data,
    input  logic [NPORTS-1:0]        empty,
    input  logic [NPORTS-1:0]        out_full,
    output logic [NPORTS*SEL_W-1:0]  sel,
    output logic [NPORTS-1:0]        rdreq
`ifdef SCHED_DROP_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);

    logic [NPORTS-1:0][DEST_W-1:0] w_dest;
    logic [NPORTS-1:0][NPORTS-1:0] w_req;
    logic [NPORTS-1:0][SEL_W-1:0]  w_sel_nxt;
    logic [NPORTS-1:0][SEL_W-1:0]  w_ptr_nxt;
    logic [NPORTS-1:0]             w_pop;
    logic [NPORTS-1:0][SEL_W-1:0]  r_sel;
    logic [NPORTS-1:0][SEL_W-1:0]  r_ptr;
    logic [NPORTS-1:0]             r_rdreq;
    logic                          w_unused_data;

    // Only the destination field of each head word matters here.
    assign w_unused_data = ^data;

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            w_dest[i] = data[i*DATA_W +: DEST_W];
        end
    end

    // r_rdreq doubles as the previous-grant mask: a popped FIFO's head is stale for one cycle.
    always_comb begin
        w_req = '0;
        for (int j = 0; j < NPORTS; j++) begin
            for (int i = 0; i < NPORTS; i++) begin
                w_req[j][i] = !empty[i] && !r_rdreq[i] && !out_full[j] &&
                              (int'(w_dest[i]) == j + 1);
            end
        end
    end

`ifdef SCHED_DROP_EN
    logic [NPORTS-1:0] w_drop;
    logic [16:0]       w_drop_sum;
    logic [15:0]       r_drop_cnt;

    always_comb begin
        w_drop     = '0;
        w_drop_sum = {1'b0, r_drop_cnt};
        for (int i = 0; i < NPORTS; i++) begin
            w_drop[i] = !empty[i] && !r_rdreq[i] &&
                        ((w_dest[i] == '0) || (int'(w_dest[i]) > NPORTS));
            if (w_drop[i]) begin
                w_drop_sum = w_drop_sum + 17'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    // Two passes give wrap-around priority: indices at/after the pointer first, then the rest.
    always_comb begin : arb
        logic found;
        found     = 1'b0;
        w_sel_nxt = '0;
        w_ptr_nxt = r_ptr;
        w_pop     = '0;
        for (int j = 0; j < NPORTS; j++) begin
            found = 1'b0;
            for (int i = 0; i < NPORTS; i++) begin
                if (!found && w_req[j][i] && (i >= int'(r_ptr[j]))) begin
                    found        = 1'b1;
                    w_sel_nxt[j] = SEL_W'(i + 1);
                    w_ptr_nxt[j] = (i + 1 == NPORTS) ? '0 : SEL_W'(i + 1);
                    w_pop[i]     = 1'b1;
                end
            end
            for (int i = 0; i < NPORTS; i++) begin
                if (!found && w_req[j][i]) begin
                    found        = 1'b1;
                    w_sel_nxt[j] = SEL_W'(i + 1);
                    w_ptr_nxt[j] = (i + 1 == NPORTS) ? '0 : SEL_W'(i + 1);
                    w_pop[i]     = 1'b1;
                end
            end
        end
`ifdef SCHED_DROP_EN
        w_pop = w_pop | w_drop;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel   <= '0;
            r_ptr   <= '0;
            r_rdreq <= '0;
        end else begin
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_rdreq <= w_pop;
        end
    end

    assign sel   = r_sel;
    assign rdreq = r_rdreq;

endmodule

// File: tb/tb_switch_scheduler_rr.sv
// Bench for switch_scheduler_rr: FIFO responder, rotation-based reference model, directed scenarios.
module tb_switch_scheduler_rr;

    localparam int NP  = 3;
    localparam int DW  = 8;
    localparam int DSW = 2;
    localparam int SW  = 2;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic [NP*DW-1:0]  data;
    logic [NP-1:0]     empty;
    logic [NP-1:0]     out_full = '0;
    logic [NP*SW-1:0]  sel;
    logic [NP-1:0]     rdreq;
`ifdef SCHED_DROP_EN
    logic [15:0]       drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    switch_scheduler_rr #(
        .NPORTS(NP), .DATA_W(DW), .DEST_W(DSW), .SEL_W(SW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .data(data),
        .empty(empty),
        .out_full(out_full),
        .sel(sel),
        .rdreq(rdreq)
`ifdef SCHED_DROP_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Input FIFOs: word count and a fixed destination per FIFO; head changes after a popped edge.
    int            fifo_cnt[NP]  = '{default: 0};
    logic [DSW-1:0] fifo_dest[NP] = '{default: '0};
    logic [NP-1:0] pop_s = '0;

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            data[i*DW +: DW] = {6'(fifo_cnt[i]), fifo_dest[i]};
            empty[i]         = (fifo_cnt[i] == 0);
        end
    end

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) pop_s = '0;
        else          pop_s = rdreq;
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NP; i++) begin
            if (pop_s[i] && fifo_cnt[i] > 0) fifo_cnt[i]--;
        end
    end

    // Reference model: each output walks inputs in rotation order starting at its pointer.
    int            mptr[NP] = '{default: 0};
    logic [NP-1:0] mprev    = '0;
    logic [NP*SW-1:0] exp_sel = '0;
    logic [NP-1:0] exp_rd   = '0;
    int            exp_drop = 0;
    logic [NP*SW-1:0] m_ns;
    logic [NP-1:0] m_nr;
    int            m_i;
    int            m_d;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < NP; j++) mptr[j] = 0;
            mprev    = '0;
            exp_sel  = '0;
            exp_rd   = '0;
            exp_drop = 0;
        end else begin
            m_ns = '0;
            m_nr = '0;
            for (int j = 0; j < NP; j++) begin
                if (!out_full[j]) begin
                    for (int k = 0; k < NP; k++) begin
                        m_i = (mptr[j] + k) % NP;
                        m_d = int'(data[m_i*DW +: DSW]);
                        if (m_ns[j*SW +: SW] == 0 && !empty[m_i] && !mprev[m_i] && m_d == j + 1) begin
                            m_ns[j*SW +: SW] = SW'(m_i + 1);
                            m_nr[m_i]        = 1'b1;
                            mptr[j]          = (m_i + 1) % NP;
                        end
                    end
                end
            end
`ifdef SCHED_DROP_EN
            for (int i = 0; i < NP; i++) begin
                m_d = int'(data[i*DW +: DSW]);
                if (!empty[i] && !mprev[i] && (m_d == 0 || m_d > NP)) begin
                    m_nr[i] = 1'b1;
                    if (exp_drop < 65535) exp_drop++;
                end
            end
`endif
            mprev   = m_nr;
            exp_sel = m_ns;
            exp_rd  = m_nr;
        end
    end

    logic [NP-1:0] cmp_prev = '0;
    int            multi;

    always @(negedge reset_n) cmp_prev = '0;

    always @(negedge clk) begin
        chk("sel_vs_model", 32'(sel), 32'(exp_sel));
        chk("rdreq_vs_model", 32'(rdreq), 32'(exp_rd));
        chk("rdreq_back_to_back", 32'(rdreq & cmp_prev), 32'd0);
        multi = 0;
        for (int i = 0; i < NP; i++) begin
            int n;
            n = 0;
            for (int j = 0; j < NP; j++) if (int'(sel[j*SW +: SW]) == i + 1) n++;
            if (n > 1) multi++;
        end
        chk("input_selected_twice", 32'(multi), 32'd0);
`ifdef SCHED_DROP_EN
        chk("drop_cnt_vs_model", 32'(drop_cnt), 32'(exp_drop));
`endif
        cmp_prev = rdreq;
    end

    int pulses;
    int sel_seen;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_rdreq", 32'(rdreq), 32'd0);
`ifdef SCHED_DROP_EN
        chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        #1 reset_n = 1'b1;

        // All inputs empty: nothing is ever granted.
        repeat (6) begin
            @(negedge clk);
            chk("idle_sel", 32'(sel), 32'd0);
            chk("idle_rdreq", 32'(rdreq), 32'd0);
        end

        // Three inputs contending for output 0.
        tick();
        for (int i = 0; i < NP; i++) begin
            fifo_dest[i] = 2'd1;
            fifo_cnt[i]  = 50;
        end
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_sel0", 32'(sel), 32'((k % 3) + 1));
            chk("rr_rdreq", 32'(rdreq), 32'(1 << (k % 3)));
        end
        tick();
        for (int i = 0; i < NP; i++) fifo_cnt[i] = 0;
        repeat (3) tick();

        // Permutation: every input to a distinct output in one cycle.
        fifo_dest[0] = 2'd2; fifo_dest[1] = 2'd3; fifo_dest[2] = 2'd1;
        for (int i = 0; i < NP; i++) fifo_cnt[i] = 1;
        @(negedge clk);
        @(negedge clk);
        chk("perm_sel", 32'(sel), 32'b10_01_11);
        chk("perm_rdreq", 32'(rdreq), 32'b111);
        repeat (3) tick();

        // Backpressure on output 1 holds off arbitration until released.
        out_full     = 3'b010;
        fifo_dest[0] = 2'd2;
        fifo_cnt[0]  = 1;
        repeat (3) begin
            @(negedge clk);
            chk("full_hold_sel", 32'(sel), 32'd0);
            chk("full_hold_rdreq", 32'(rdreq), 32'd0);
        end
        tick();
        out_full = 3'b000;
        @(negedge clk);
        @(negedge clk);
        chk("full_release_sel", 32'(sel), 32'b00_01_00);
        chk("full_release_rdreq", 32'(rdreq), 32'b001);
        repeat (3) tick();

        // Undeliverable head on input 2.
        fifo_dest[2] = 2'd0;
        fifo_cnt[2]  = 5;
        pulses   = 0;
        sel_seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (rdreq[2]) pulses++;
            if (sel != '0) sel_seen++;
        end
        chk("drop_sel_quiet", 32'(sel_seen), 32'd0);
`ifdef SCHED_DROP_EN
        chk("drop_pulses", 32'(pulses), 32'd5);
        chk("drop_cnt_final", 32'(drop_cnt), 32'd5);
`else
        chk("stall_pulses", 32'(pulses), 32'd0);
`endif
        tick();
        fifo_cnt[2] = 0;
        repeat (3) tick();

        // Reset lands while a grant is visible; pointer and mask restart.
        fifo_dest[0] = 2'd1; fifo_dest[2] = 2'd1;
        fifo_cnt[0]  = 1;
        tick();
        fifo_cnt[2] = 3;
        @(negedge clk);
        chk("pre_reset_sel", 32'(sel), 32'b00_00_01);
        #1 reset_n = 1'b0;
        #1;
        chk("async_reset_sel", 32'(sel), 32'd0);
        chk("async_reset_rdreq", 32'(rdreq), 32'd0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_sel", 32'(sel), 32'b00_00_01);
        chk("post_reset_rdreq", 32'(rdreq), 32'b001);
        tick();
        for (int i = 0; i < NP; i++) fifo_cnt[i] = 0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
